led_matrix_scanner: RTL and testbench

//  Consumes the 8x8 display frame (8 row bytes) from the display-translation stage.

---
 rtl/led_matrix_scanner.sv | 148 ++++++++++++++
 tb/tb_led_matrix_scanner.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_matrix_scanner.sv
// -----------------------------------------------------------------------------
// led_matrix_scanner
//   Scans an 8x8 frame one row at a time onto an LED matrix that is driven by
//   two daisy-chained 74HC595 shift registers. Each row is sent as a 16-bit word
//   {row_select, column_pixels}, MSB first. The word is then latched, and the row
//   stays lit for DWELL_CYCLES clocks. The frame is copied into a snapshot at
//   the start of every scan (row 0), so the displayed image never tears.
//
// Ports
//   clk         system clock, all logic on posedge
//   rst_n       asynchronous active-low reset
//   enable      1 = keep scanning; 0 = go blank once the current row finishes
//   frame[0:7]  row bytes; frame[r][7] is the leftmost column
//   ser_data    serial data into the 595 chain
//   ser_clk     595 shift clock (idles low)
//   ser_latch   595 storage-register latch pulse
//   oe_n        595 output enable, active low
//   row_idx     row currently being shifted / displayed
//   frame_done  1-cycle pulse after the row-7 dwell
//   scan_state  debug view of the FSM state (IDLE/LOAD/SHIFT/LATCH/DWELL)
//
// Flow control: there is no valid/ready handshake. enable is a level and is
// sampled only in IDLE (to start) and at the end of DWELL (to continue). frame
// is sampled only in the LOAD cycle of row 0.
// -----------------------------------------------------------------------------
module led_matrix_scanner #(
  parameter int CLK_DIV      = 2,
  parameter int DWELL_CYCLES = 100,
  parameter bit ROW_ACT_LOW  = 1'b0,
  parameter bit COL_ACT_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] frame [0:7],
  output logic       ser_data,
  output logic       ser_clk,
  output logic       ser_latch,
  output logic       oe_n,
  output logic [2:0] row_idx,
  output logic       frame_done,
  output logic [2:0] scan_state
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] LATCH = 3'd3;
  localparam logic [2:0] DWELL = 3'd4;

  // One counter serves the shift-clock phase, the latch pulse and the dwell,
  // so it is sized for the longest of them.
  localparam int CNT_MAX = (CLK_DIV > DWELL_CYCLES) ? CLK_DIV : DWELL_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic          half;      // 0 = low phase of the current bit, 1 = high phase
  logic [3:0]    bit_cnt;
  logic [15:0]   shreg;
  logic          lit;       // previous row is still displayed while shifting
  logic [7:0]    snapshot [0:7];
  logic [7:0]    row_byte;
  logic [7:0]    col_byte;

  always_comb begin
    row_byte = (8'b1 << row_idx) ^ {8{ROW_ACT_LOW}};
    // Row 0 uses the live frame because the snapshot is written in this same cycle.
    col_byte = ((row_idx == 3'd0) ? frame[0] : snapshot[row_idx]) ^ {8{COL_ACT_LOW}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      half       <= 1'b0;
      bit_cnt    <= 4'd0;
      shreg      <= 16'd0;
      lit        <= 1'b0;
      row_idx    <= 3'd0;
      frame_done <= 1'b0;
      for (int i = 0; i < 8; i++) snapshot[i] <= 8'd0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          lit <= 1'b0;
          if (enable) state <= LOAD;
        end
        LOAD: begin
          if (row_idx == 3'd0) begin
            for (int i = 0; i < 8; i++) snapshot[i] <= frame[i];
          end
          shreg   <= {row_byte, col_byte};
          cnt     <= '0;
          half    <= 1'b0;
          bit_cnt <= 4'd0;
          state   <= SHIFT;
        end
        SHIFT: begin
          if (cnt == DIV_LAST) begin
            cnt <= '0;
            if (!half) begin
              half <= 1'b1;
            end else begin
              // End of the high phase: next bit appears as the clock falls.
              half  <= 1'b0;
              shreg <= {shreg[14:0], 1'b0};
              if (bit_cnt == 4'd15) state <= LATCH;
              else bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        LATCH: begin
          if (cnt == DIV_LAST) begin
            cnt   <= '0;
            state <= DWELL;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DWELL: begin
          if (cnt == DWELL_LAST) begin
            cnt        <= '0;
            row_idx    <= row_idx + 3'd1;
            frame_done <= (row_idx == 3'd7);
            lit        <= enable;
            state      <= enable ? LOAD : IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ser_clk    = (state == SHIFT) && half;
  assign ser_data   = (state == SHIFT) && shreg[15];
  assign ser_latch  = (state == LATCH);
  assign oe_n       = !((state == DWELL) || (lit && ((state == LOAD) || (state == SHIFT))));
  assign scan_state = state;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// -----------------------------------------------------------------------------
// tb_led_matrix_scanner
//   dut_a: default timing (CLK_DIV=2, DWELL_CYCLES=100), rows active high,
//          columns active low.
//   dut_b: fastest timing (CLK_DIV=1, DWELL_CYCLES=1), same polarities.
//   Monitors rebuild the 16-bit words from ser_clk rising edges and record the
//   latch/frame_done timing. The tests compare these against words computed from
//   the frame contents that were presented to each scan.
// -----------------------------------------------------------------------------
module tb_led_matrix_scanner;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       enable_a = 1'b0, enable_b = 1'b0;
  logic [7:0] frame [0:7];
  logic       a_sdata, a_sclk, a_lat, a_oe_n, a_fd;
  logic [2:0] a_row, a_state;
  logic       b_sdata, b_sclk, b_lat, b_oe_n, b_fd;
  logic [2:0] b_row, b_state;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [2:0]  idle_code;

  led_matrix_scanner #(.CLK_DIV(2), .DWELL_CYCLES(100), .ROW_ACT_LOW(1'b0), .COL_ACT_LOW(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable_a), .frame(frame),
    .ser_data(a_sdata), .ser_clk(a_sclk), .ser_latch(a_lat), .oe_n(a_oe_n),
    .row_idx(a_row), .frame_done(a_fd), .scan_state(a_state)
  );

  led_matrix_scanner #(.CLK_DIV(1), .DWELL_CYCLES(1), .ROW_ACT_LOW(1'b0), .COL_ACT_LOW(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable_b), .frame(frame),
    .ser_data(b_sdata), .ser_clk(b_sclk), .ser_latch(b_lat), .oe_n(b_oe_n),
    .row_idx(b_row), .frame_done(b_fd), .scan_state(b_state)
  );

  // ---------------- reference model ----------------
  // Word for row r: one-hot row select (active high), then the pixel byte with
  // lit pixels driven low.
  function automatic logic [15:0] row_word(input int r, input logic [7:0] pixels);
    logic [7:0] sel;
    sel = 8'(2 ** r);
    return {sel, ~pixels};
  endfunction

  // ---------------- monitors ----------------
  int cyc = 0;
  always @(posedge clk) cyc++;

  int          a_bits, a_rises, a_lat_start, a_fd_start, a_oe_bad;
  logic [15:0] a_sh;
  logic        a_prev_clk, a_prev_lat, a_prev_fd;
  logic [15:0] a_word_q[$];
  int          a_first_q[$], a_lat_start_q[$], a_lat_len_q[$], a_fd_q[$], a_fd_len_q[$];
  logic [2:0]  a_lat_row_q[$];
  logic        a_oe_shift_q[$], a_oe_dwell_q[$];

  int          b_bits, b_stab_seen, b_stab_bad;
  logic [15:0] b_sh;
  logic        b_prev_clk, b_prev_lat, b_prev_data;
  logic [15:0] b_word_q[$];
  int          b_lat_q[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      a_bits = 0; a_prev_clk = 1'b0; a_prev_lat = 1'b0; a_prev_fd = 1'b0; a_oe_bad = 0;
      a_word_q.delete(); a_first_q.delete(); a_lat_start_q.delete(); a_lat_len_q.delete();
      a_fd_q.delete(); a_fd_len_q.delete(); a_lat_row_q.delete();
      a_oe_shift_q.delete(); a_oe_dwell_q.delete();
      b_bits = 0; b_prev_clk = 1'b0; b_prev_lat = 1'b0; b_prev_data = 1'b0;
      b_stab_seen = 0; b_stab_bad = 0; b_word_q.delete(); b_lat_q.delete();
    end else begin
      if (a_sclk && !a_prev_clk) begin
        if (a_bits == 0) begin a_first_q.push_back(cyc); a_oe_shift_q.push_back(a_oe_n); end
        a_sh = {a_sh[14:0], a_sdata};
        a_bits++; a_rises++;
        if (a_bits == 16) begin a_word_q.push_back(a_sh); a_bits = 0; end
      end
      if (a_lat) begin
        if (!a_oe_n) a_oe_bad++;
        if (!a_prev_lat) begin a_lat_start = cyc; a_lat_row_q.push_back(a_row); end
      end else if (a_prev_lat) begin
        a_lat_start_q.push_back(a_lat_start);
        a_lat_len_q.push_back(cyc - a_lat_start);
        a_oe_dwell_q.push_back(a_oe_n);
      end
      if (a_fd && !a_prev_fd) begin a_fd_q.push_back(cyc); a_fd_start = cyc; end
      if (!a_fd && a_prev_fd) a_fd_len_q.push_back(cyc - a_fd_start);
      a_prev_clk = a_sclk; a_prev_lat = a_lat; a_prev_fd = a_fd;

      if (b_sclk && !b_prev_clk) begin
        b_stab_seen++;
        if (b_sdata !== b_prev_data) b_stab_bad++;
        b_sh = {b_sh[14:0], b_sdata};
        b_bits++;
        if (b_bits == 16) begin b_word_q.push_back(b_sh); b_bits = 0; end
      end
      if (b_lat && !b_prev_lat) b_lat_q.push_back(cyc);
      b_prev_clk = b_sclk; b_prev_lat = b_lat; b_prev_data = b_sdata;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; enable_a = 1'b0; enable_b = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic random_frame();
    for (int i = 0; i < 8; i++) frame[i] = 8'($urandom_range(0, 255));
  endtask

  function automatic int probe(input int which);
    case (which)
      0: return a_word_q.size();
      1: return a_lat_len_q.size();
      2: return a_fd_len_q.size();
      3: return a_bits;
      4: return b_lat_q.size();
      default: return 0;
    endcase
  endfunction

  task automatic wait_for(input int which, input int n, input int budget, input string what);
    int k = 0;
    while (probe(which) < n && k < budget) begin @(negedge clk); k++; end
    if (probe(which) < n) begin
      checks++; errors++;
      $display("FAIL timeout_%s: reached %0d, required %0d within %0d cycles", what, probe(which), n, budget);
    end
  endtask

  task automatic wait_row_a(input logic [2:0] r, input int budget);
    int k = 0;
    while (a_row !== r && k < budget) begin @(negedge clk); k++; end
    if (a_row !== r) begin
      checks++; errors++;
      $display("FAIL timeout_row: row_idx %0d, required %0d within %0d cycles", a_row, r, budget);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int base;
    random_frame();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    idle_code = a_state;
    checks++; if (a_oe_n !== 1'b1) begin errors++; $display("FAIL reset_oe_n: got %b required 1", a_oe_n); end
    checks++; if (a_sclk !== 1'b0) begin errors++; $display("FAIL reset_ser_clk: got %b required 0", a_sclk); end
    checks++; if (a_lat !== 1'b0) begin errors++; $display("FAIL reset_ser_latch: got %b required 0", a_lat); end
    checks++; if (a_sdata !== 1'b0) begin errors++; $display("FAIL reset_ser_data: got %b required 0", a_sdata); end
    checks++; if (a_row !== 3'd0) begin errors++; $display("FAIL reset_row_idx: got %0d required 0", a_row); end
    checks++; if (a_fd !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b required 0", a_fd); end
    checks++; if (b_state !== a_state) begin errors++; $display("FAIL reset_state_b: got %0d required %0d", b_state, a_state); end
    rst_n = 1'b1;
    enable_a = 1'b1;
    // Reset in the middle of shifting row 1.
    wait_row_a(3'd1, 400);
    wait_for(3, 5, 200, "mid_shift");
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++; if (a_oe_n !== 1'b1) begin errors++; $display("FAIL midreset_oe_n: got %b required 1", a_oe_n); end
    checks++; if (a_sclk !== 1'b0) begin errors++; $display("FAIL midreset_ser_clk: got %b required 0", a_sclk); end
    checks++; if (a_lat !== 1'b0) begin errors++; $display("FAIL midreset_ser_latch: got %b required 0", a_lat); end
    checks++; if (a_row !== 3'd0) begin errors++; $display("FAIL midreset_row_idx: got %0d required 0", a_row); end
    enable_a = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = a_rises;
    repeat (60) @(negedge clk);
    checks++; if (a_rises !== base) begin errors++; $display("FAIL hold_ser_clk_edges: got %0d required %0d", a_rises, base); end
    checks++; if (a_oe_n !== 1'b1) begin errors++; $display("FAIL hold_oe_n: got %b required 1", a_oe_n); end
    checks++; if (a_row !== 3'd0) begin errors++; $display("FAIL hold_row_idx: got %0d required 0", a_row); end
    checks++; if (a_word_q.size() !== 0) begin errors++; $display("FAIL hold_words: got %0d required 0", a_word_q.size()); end
    checks++; if (a_state !== idle_code) begin errors++; $display("FAIL hold_state: got %0d required %0d", a_state, idle_code); end
  endtask

  task automatic test_single_row();
    logic [15:0] got, exp;
    do_reset();
    random_frame();
    frame[0] = 8'hA5;
    exp_q.push_back(16'h015A);
    exp_q.push_back(row_word(1, frame[1]));
    enable_a = 1'b1;
    wait_for(0, 2, 600, "single_row_words");
    for (int k = 0; k < 2; k++) begin
      exp = exp_q.pop_front();
      got = (a_word_q.size() > 0) ? a_word_q.pop_front() : 16'hxxxx;
      checks++; if (got !== exp) begin errors++; $display("FAIL single_row_word%0d: got %h required %h", k, got, exp); end
    end
    checks++; if (a_lat_len_q[0] !== 2) begin errors++; $display("FAIL latch_width: got %0d required 2", a_lat_len_q[0]); end
    checks++;
    if (a_lat_start_q[0] - a_first_q[0] !== 62) begin
      errors++; $display("FAIL latch_offset: got %0d required 62", a_lat_start_q[0] - a_first_q[0]);
    end
    checks++; if (a_oe_bad !== 0) begin errors++; $display("FAIL latch_blank: got %0d lit cycles required 0", a_oe_bad); end
    checks++; if (a_oe_dwell_q[0] !== 1'b0) begin errors++; $display("FAIL dwell_oe_n: got %b required 0", a_oe_dwell_q[0]); end
    checks++; if (a_oe_shift_q[0] !== 1'b1) begin errors++; $display("FAIL first_shift_oe_n: got %b required 1", a_oe_shift_q[0]); end
    checks++; if (a_oe_shift_q[1] !== 1'b0) begin errors++; $display("FAIL second_shift_oe_n: got %b required 0", a_oe_shift_q[1]); end
    enable_a = 1'b0;
  endtask

  task automatic test_full_scan();
    logic [15:0] got, exp;
    do_reset();
    for (int i = 0; i < 8; i++) frame[i] = 8'(i);
    enable_a = 1'b1;
    wait_for(2, 3, 3 * 1336 + 400, "frame_done");
    for (int k = 0; k < 16; k++) exp_q.push_back(row_word(k % 8, 8'(k % 8)));
    for (int k = 0; k < 16; k++) begin
      exp = exp_q.pop_front();
      got = (a_word_q.size() > 0) ? a_word_q.pop_front() : 16'hxxxx;
      checks++; if (got !== exp) begin errors++; $display("FAIL scan_word%0d: got %h required %h", k, got, exp); end
      checks++;
      if (a_lat_row_q[k] !== 3'(k % 8)) begin
        errors++; $display("FAIL scan_row_idx%0d: got %0d required %0d", k, a_lat_row_q[k], k % 8);
      end
    end
    for (int k = 1; k < 3; k++) begin
      checks++;
      if (a_fd_q[k] - a_fd_q[k-1] !== 1336) begin
        errors++; $display("FAIL frame_period%0d: got %0d required 1336", k, a_fd_q[k] - a_fd_q[k-1]);
      end
    end
    for (int k = 0; k < 3; k++) begin
      checks++; if (a_fd_len_q[k] !== 1) begin errors++; $display("FAIL frame_done_width%0d: got %0d required 1", k, a_fd_len_q[k]); end
    end
    enable_a = 1'b0;
  endtask

  task automatic test_tearing();
    logic [7:0]  hist [0:4][0:7];
    logic [15:0] got [0:31];
    logic [15:0] exp;
    do_reset();
    random_frame();
    frame[5] = 8'h00;
    for (int i = 0; i < 8; i++) hist[0][i] = frame[i];
    enable_a = 1'b1;
    for (int f = 0; f < 4; f++) begin
      wait_row_a(3'd3, 2000);
      if (f == 0) frame[5] = 8'hFF;
      else random_frame();
      for (int i = 0; i < 8; i++) hist[f+1][i] = frame[i];
      wait_row_a(3'd4, 400);
    end
    wait_for(0, 32, 1500, "tearing_words");
    for (int k = 0; k < 32; k++) exp_q.push_back(row_word(k % 8, hist[k / 8][k % 8]));
    for (int k = 0; k < 32; k++) begin
      got[k] = (a_word_q.size() > 0) ? a_word_q.pop_front() : 16'hxxxx;
      exp = exp_q.pop_front();
      checks++; if (got[k] !== exp) begin errors++; $display("FAIL tearing_word%0d: got %h required %h", k, got[k], exp); end
    end
    checks++; if (got[5][7:0] !== 8'hFF) begin errors++; $display("FAIL tearing_row5_old: got %h required ff", got[5][7:0]); end
    checks++; if (got[13][7:0] !== 8'h00) begin errors++; $display("FAIL tearing_row5_new: got %h required 00", got[13][7:0]); end
    enable_a = 1'b0;
  endtask

  task automatic test_enable_drop();
    logic [7:0]  snap [0:7];
    logic [15:0] got, exp;
    do_reset();
    random_frame();
    for (int i = 0; i < 8; i++) snap[i] = frame[i];
    enable_a = 1'b1;
    wait_row_a(3'd2, 1000);
    wait_for(3, 3, 200, "row2_shift");
    enable_a = 1'b0;
    repeat (400) @(negedge clk);
    checks++; if (a_row !== 3'd3) begin errors++; $display("FAIL drop_row_idx: got %0d required 3", a_row); end
    checks++; if (a_oe_n !== 1'b1) begin errors++; $display("FAIL drop_oe_n: got %b required 1", a_oe_n); end
    checks++; if (a_sclk !== 1'b0) begin errors++; $display("FAIL drop_ser_clk: got %b required 0", a_sclk); end
    checks++; if (a_lat_len_q.size() !== 3) begin errors++; $display("FAIL drop_latches: got %0d required 3", a_lat_len_q.size()); end
    checks++; if (a_word_q.size() !== 3) begin errors++; $display("FAIL drop_words: got %0d required 3", a_word_q.size()); end
    checks++; if (a_state !== idle_code) begin errors++; $display("FAIL drop_state: got %0d required %0d", a_state, idle_code); end
    // New frame while idle must not show until the next row-0 snapshot.
    random_frame();
    enable_a = 1'b1;
    wait_for(0, 9, 1400, "resume_words");
    for (int k = 0; k < 8; k++) exp_q.push_back(row_word(k, snap[k]));
    exp_q.push_back(row_word(0, frame[0]));
    for (int k = 0; k < 9; k++) begin
      exp = exp_q.pop_front();
      got = (a_word_q.size() > 0) ? a_word_q.pop_front() : 16'hxxxx;
      checks++; if (got !== exp) begin errors++; $display("FAIL resume_word%0d: got %h required %h", k, got, exp); end
    end
    checks++; if (a_oe_shift_q[3] !== 1'b1) begin errors++; $display("FAIL resume_oe_n: got %b required 1", a_oe_shift_q[3]); end
    enable_a = 1'b0;
  endtask

  task automatic test_timing();
    logic [15:0] got, exp;
    do_reset();
    random_frame();
    enable_b = 1'b1;
    wait_for(4, 6, 400, "fast_latches");
    for (int k = 1; k < 6; k++) begin
      checks++;
      if (b_lat_q[k] - b_lat_q[k-1] !== 35) begin
        errors++; $display("FAIL fast_row_period%0d: got %0d required 35", k, b_lat_q[k] - b_lat_q[k-1]);
      end
    end
    for (int k = 0; k < 6; k++) exp_q.push_back(row_word(k, frame[k]));
    for (int k = 0; k < 6; k++) begin
      exp = exp_q.pop_front();
      got = (b_word_q.size() > 0) ? b_word_q.pop_front() : 16'hxxxx;
      checks++; if (got !== exp) begin errors++; $display("FAIL fast_word%0d: got %h required %h", k, got, exp); end
    end
    checks++; if (b_stab_bad !== 0) begin errors++; $display("FAIL fast_data_stable: got %0d unstable edges required 0", b_stab_bad); end
    checks++; if (b_stab_seen < 96) begin errors++; $display("FAIL fast_edge_count: got %0d required at least 96", b_stab_seen); end
    enable_b = 1'b0;
  endtask

  // ---------------- sequence / final report ----------------
  initial begin
    for (int i = 0; i < 8; i++) frame[i] = 8'd0;
    test_reset();
    test_single_row();
    test_full_scan();
    test_tearing();
    test_enable_drop();
    test_timing();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
